// File: rtl/conv_result_collector.sv
// conv_result_collector
// Accepts strobe-tagged MAC results and turns them into raster-ordered
// feature-map buffer writes (linear address row*FM_W+col), with optional
// ReLU, row/frame completion pulses and a sticky stray-strobe flag.
module conv_result_collector #(
  parameter int DATA_W = 16,
  parameter int FM_W   = 24,
  parameter int FM_H   = 24,
  parameter int ADDR_W = 10,
  parameter int RELU   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              row_done,
  output logic              frame_done,
  output logic              busy,
  output logic              stray_err
);

  localparam int COL_W = (FM_W > 1) ? $clog2(FM_W) : 1;
  localparam int ROW_W = (FM_H > 1) ? $clog2(FM_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FM_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FM_H - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // ReLU on the sign bit only; the value is never rescaled or saturated.
  function automatic logic [DATA_W-1:0] relu_f(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    if ((RELU != 0) && d[DATA_W-1]) begin
      r = '0;
    end else begin
      r = d;
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              row_done_q, row_done_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              stray_q, stray_d;

  // Next-state logic: FSM, raster counters and the registered write port.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    lin_d        = lin_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    stray_d      = stray_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A strobe coinciding with start is dropped but still flagged.
          state_d = S_COLLECT;
          col_d   = '0;
          row_d   = '0;
          lin_d   = '0;
          stray_d = in_valid;
        end else if (in_valid) begin
          stray_d = 1'b1;
        end else begin
          stray_d = stray_q;
        end
      end

      S_COLLECT: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = lin_q;
          wr_data_d = relu_f(in_data);
          if (col_q == COL_LAST) begin
            row_done_d = 1'b1;
            col_d      = '0;
            if (row_q == ROW_LAST) begin
              // Last pixel of the frame: counters clear, FSM moves on.
              frame_done_d = 1'b1;
              row_d        = '0;
              lin_d        = '0;
              state_d      = S_DONE;
            end else begin
              row_d = row_q + ROW_W'(1);
              lin_d = lin_q + ADDR_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
            lin_d = lin_q + ADDR_W'(1);
          end
        end else begin
          col_d = col_q;
          lin_d = lin_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (in_valid) begin
          stray_d = 1'b1;
        end else begin
          stray_d = stray_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_COLLECT);
  end

  // State and output registers; reset clears everything, including a pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      lin_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      lin_q        <= lin_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      stray_q      <= stray_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign stray_err  = stray_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector with a 4x3 feature map.
// Two instances share stimulus: one with ReLU, one pass-through.
module tb_conv_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b1;
  logic [15:0] in_data = 16'd0;

  logic        wr_en, row_done, frame_done, busy, stray_err;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en0, row_done0, frame_done0, busy0, stray_err0;
  logic [9:0]  wr_addr0;
  logic [15:0] wr_data0;

  conv_result_collector #(.DATA_W(16), .FM_W(4), .FM_H(3), .ADDR_W(10), .RELU(1)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .row_done(row_done),
    .frame_done(frame_done), .busy(busy), .stray_err(stray_err)
  );

  conv_result_collector #(.DATA_W(16), .FM_W(4), .FM_H(3), .ADDR_W(10), .RELU(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .row_done(row_done0),
    .frame_done(frame_done0), .busy(busy0), .stray_err(stray_err0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] d1;
    logic [15:0] d0;
    logic        rd;
    logic        fd;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          m_state = 0;
  int          m_idx = 0;
  logic        m_stray = 1'b0;
  logic [9:0]  last_addr = 10'd0;
  logic [15:0] last_d1 = 16'd0;
  logic [15:0] last_d0 = 16'd0;
  int          fd_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame position tracked as a single pixel index.
  task automatic model_step(input logic s, input logic v, input logic [15:0] d);
    exp_t e;
    case (m_state)
      0: begin
        if (s) begin
          m_state = 1;
          m_idx   = 0;
          m_stray = v;
        end else if (v) begin
          m_stray = 1'b1;
        end
      end
      1: begin
        if (v) begin
          e.addr = 10'(m_idx);
          e.d1   = ($signed(d) < 0) ? 16'd0 : d;
          e.d0   = d;
          e.rd   = ((m_idx % 4) == 3);
          e.fd   = (m_idx == 11);
          q.push_back(e);
          m_idx++;
          if (m_idx == 12) begin
            m_idx   = 0;
            m_state = 2;
          end
        end
      end
      default: begin
        m_state = 0;
        if (v) m_stray = 1'b1;
      end
    endcase
  endtask

  task automatic check_cycle();
    exp_t e;
    if (frame_done === 1'b1) fd_count++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wr_en", 32'(wr_en), 32'd1);
      chk("wr_addr", 32'(wr_addr), 32'(e.addr));
      chk("wr_data", 32'(wr_data), 32'(e.d1));
      chk("row_done", 32'(row_done), 32'(e.rd));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      chk("wr_en_norelu", 32'(wr_en0), 32'd1);
      chk("wr_addr_norelu", 32'(wr_addr0), 32'(e.addr));
      chk("wr_data_norelu", 32'(wr_data0), 32'(e.d0));
      chk("frame_done_norelu", 32'(frame_done0), 32'(e.fd));
      last_addr = e.addr;
      last_d1   = e.d1;
      last_d0   = e.d0;
    end else begin
      chk("wr_en_idle", 32'(wr_en), 32'd0);
      chk("row_done_idle", 32'(row_done), 32'd0);
      chk("frame_done_idle", 32'(frame_done), 32'd0);
      chk("wr_addr_hold", 32'(wr_addr), 32'(last_addr));
      chk("wr_data_hold", 32'(wr_data), 32'(last_d1));
      chk("wr_data_hold_norelu", 32'(wr_data0), 32'(last_d0));
      chk("wr_en_idle_norelu", 32'(wr_en0), 32'd0);
    end
    chk("busy", 32'(busy), (m_state == 1) ? 32'd1 : 32'd0);
    chk("stray_err", 32'(stray_err), 32'(m_stray));
    chk("stray_err_norelu", 32'(stray_err0), 32'(m_stray));
  endtask

  task automatic cyc(input logic s, input logic v, input logic [15:0] d);
    start    = s;
    in_valid = v;
    in_data  = d;
    model_step(s, v, d);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_row_done"}, 32'(row_done), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stray_err"}, 32'(stray_err), 32'd0);
    chk({tag, "_wr_en_norelu"}, 32'(wr_en0), 32'd0);
    chk({tag, "_wr_data_norelu"}, 32'(wr_data0), 32'd0);
  endtask

  // Reset asserted mid-cycle with a strobe present; outputs must clear at once.
  task automatic rst_mid();
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    m_state   = 0;
    m_idx     = 0;
    m_stray   = 1'b0;
    q.delete();
    last_addr = 10'd0;
    last_d1   = 16'd0;
    last_d0   = 16'd0;
    #2;
    in_valid = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic samples(input int n, input int gap, input int base, input int stepv);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 16'(base + i * stepv));
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 16'd0);
    end
  endtask

  initial begin
    // Power-on reset with a strobe present.
    #2;
    check_reset_outputs("por");
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 16'd0);

    // Full back-to-back frame, data -6..5.
    cyc(1'b1, 1'b0, 16'd0);
    samples(12, 0, -6, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'd0);

    // Gapped frame: a strobe every third cycle.
    cyc(1'b1, 1'b0, 16'd0);
    samples(12, 2, -5000, 1000);
    cyc(1'b0, 1'b0, 16'd0);

    // Most-negative value first, a start ignored mid-frame, then ignored in DONE.
    cyc(1'b1, 1'b0, 16'd0);
    cyc(1'b0, 1'b1, 16'h8000);
    cyc(1'b0, 1'b1, 16'h7fff);
    cyc(1'b0, 1'b1, 16'hffff);
    cyc(1'b1, 1'b1, 16'h0001);
    cyc(1'b1, 1'b0, 16'd0);
    samples(8, 0, 16'h1234, 16'h0101);
    cyc(1'b1, 1'b1, 16'h0042);
    cyc(1'b0, 1'b0, 16'd0);

    // Stray strobe in IDLE, cleared by start; then start and strobe together.
    cyc(1'b0, 1'b1, 16'h0055);
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0);
    samples(12, 0, 100, -20);
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b1, 16'h0777);
    samples(12, 1, -3, 1);
    cyc(1'b0, 1'b0, 16'd0);

    // Reset after the 6th sample, then a clean frame.
    cyc(1'b1, 1'b0, 16'd0);
    samples(6, 0, 7, 3);
    rst_mid();
    fd_count = 0;
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0);
    samples(12, 0, -11, 2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'd0);
    chk("frame_done_count", 32'(fd_count), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
